// File: rtl/snd_fifo_player.sv
// Sound-DMA sink: buffers 16-bit words from the MCU load strobe and plays them
// out as signed 8-bit L/R samples at a rate derived from the 8 MHz enable.
module snd_fifo_player #(
  parameter int DEPTH     = 4,
  parameter int SREQ_FREE = 2,
  parameter int BASE_DIV  = 160
) (
  input  logic        clk32_i,
  input  logic        reset_i,
  input  logic        mhz8_en_i,
  input  logic        sndon_i,
  input  logic        mono_i,
  input  logic [1:0]  rate_i,
  input  logic        sload_n_i,
  input  logic [15:0] din_i,
  output logic        sreq_o,
  output logic [7:0]  sample_l_o,
  output logic [7:0]  sample_r_o,
  output logic        sample_stb_o,
  output logic        underrun_o,
  output logic        overrun_o
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int DIVW = $clog2(BASE_DIV * 8 + 1);

  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [DIVW-1:0] div_q, lim_q, lim_sel;
  logic            phase_q, sload_prev_q, sreq_q, sreq_d;
  logic [7:0]      sample_l_q, sample_r_q, samp_l_d, samp_r_d;
  logic            stb_q, und_q, ovr_q;

  logic [15:0] head;
  logic [1:0]  sh;
  logic        tick, empty, full, push_req, push, pop, play, drop;

  always_comb begin
    head     = mem_q[rd_q];
    sh       = 2'd3 - rate_i;
    lim_sel  = DIVW'(BASE_DIV) << sh;
    tick     = sndon_i & mhz8_en_i & (div_q == (lim_q - DIVW'(1)));
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    push_req = sndon_i & ~reset_i & ~sload_n_i & sload_prev_q;
    play     = tick & ~empty;
    // mono consumes a word over two ticks: high byte first, then low byte + pop
    pop      = play & (~mono_i | phase_q);
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    count_d  = count_q + CW'(push) - CW'(pop);
    sreq_d   = sndon_i & ~reset_i & ((CW'(DEPTH) - count_d) >= CW'(SREQ_FREE));
    samp_l_d = head[15:8];
    samp_r_d = head[7:0];
    if (mono_i) begin
      samp_l_d = phase_q ? head[7:0] : head[15:8];
      samp_r_d = samp_l_d;
    end
  end

  always_ff @(posedge clk32_i) begin
    if (push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk32_i) begin
    if (reset_i) begin
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      div_q        <= '0;
      lim_q        <= lim_sel;
      phase_q      <= 1'b0;
      sload_prev_q <= 1'b1;
      sreq_q       <= 1'b0;
      sample_l_q   <= '0;
      sample_r_q   <= '0;
      stb_q        <= 1'b0;
      und_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      sload_prev_q <= sload_n_i;
      sreq_q       <= sreq_d;
      if (!sndon_i) begin
        rd_q       <= '0;
        wr_q       <= '0;
        count_q    <= '0;
        div_q      <= '0;
        lim_q      <= lim_sel;
        phase_q    <= 1'b0;
        sample_l_q <= '0;
        sample_r_q <= '0;
        stb_q      <= 1'b0;
        und_q      <= 1'b0;
        ovr_q      <= 1'b0;
      end else begin
        rd_q    <= rd_q + AW'(pop);
        wr_q    <= wr_q + AW'(push);
        count_q <= count_d;
        // divider limit is latched at reload so rate changes land on a period boundary
        if (tick) begin
          div_q <= '0;
          lim_q <= lim_sel;
        end else if (mhz8_en_i) begin
          div_q <= div_q + DIVW'(1);
        end
        if (play) begin
          phase_q    <= mono_i ? ~phase_q : 1'b0;
          sample_l_q <= samp_l_d;
          sample_r_q <= samp_r_d;
        end
        stb_q <= play;
        und_q <= tick & empty;
        ovr_q <= drop;
      end
    end
  end

  assign sreq_o       = sreq_q;
  assign sample_l_o   = sample_l_q;
  assign sample_r_o   = sample_r_q;
  assign sample_stb_o = stb_q;
  assign underrun_o   = und_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_snd_fifo_player.sv
// Directed scoreboard bench for snd_fifo_player: expected samples are queued at
// load time and matched against each strobe, along with the tick timing.
module tb_snd_fifo_player;

  logic        clk32, reset, mhz8_en, sndon, mono, sload_n;
  logic [1:0]  rate;
  logic [15:0] din;
  logic        sreq, sample_stb, underrun, overrun;
  logic [7:0]  sample_l, sample_r;

  snd_fifo_player dut (
    .clk32_i(clk32), .reset_i(reset), .mhz8_en_i(mhz8_en), .sndon_i(sndon),
    .mono_i(mono), .rate_i(rate), .sload_n_i(sload_n), .din_i(din),
    .sreq_o(sreq), .sample_l_o(sample_l), .sample_r_o(sample_r),
    .sample_stb_o(sample_stb), .underrun_o(underrun), .overrun_o(overrun)
  );

  int checks = 0;
  int errors = 0;
  int en_seen = 0;
  int und_cnt = 0;
  int ovr_cnt = 0;
  int base = 0;
  logic [15:0] exp_q[$];
  logic [47:0] obs_q[$];

  initial begin
    clk32 = 1'b0;
    forever #5 clk32 = ~clk32;
  end

  initial begin
    int ph;
    ph = 0;
    mhz8_en = 1'b0;
    forever begin
      @(negedge clk32);
      ph = (ph + 1) % 4;
      mhz8_en = (ph == 0);
    end
  end

  // enables the DUT divider actually counts
  always @(posedge clk32)
    if (mhz8_en && sndon && !reset) en_seen++;

  always @(negedge clk32) begin
    if (sample_stb) obs_q.push_back({en_seen, sample_l, sample_r});
    if (underrun) und_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk32);
    #1;
  endtask

  task automatic load(input logic [15:0] w, input bit expect_kept);
    sload_n = 1'b0;
    din = w;
    if (expect_kept) exp_q.push_back(w);
    step();
    sload_n = 1'b1;
    step();
  endtask

  // pops the next observed strobe and compares samples and tick position
  task automatic take_sample(input string tag, input int exp_en);
    logic [47:0] o;
    logic [15:0] e;
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 8000) begin
      step();
      n++;
    end
    chk({tag, "_stb_seen"}, obs_q.size() > 0, 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk({tag, "_l"}, o[15:8], e[15:8]);
      chk({tag, "_r"}, o[7:0], e[7:0]);
      chk({tag, "_enables"}, o[47:16] - base, exp_en);
    end
  endtask

  task automatic wait_underrun(input string tag);
    int u0, n;
    u0 = und_cnt;
    n = 0;
    while (und_cnt == u0 && n < 8000) begin
      step();
      n++;
    end
    chk({tag, "_underrun"}, und_cnt - u0, 1);
  endtask

  task automatic restart(input logic m, input logic [1:0] r);
    mono = m;
    rate = r;
    sndon = 1'b0;
    step();
    sndon = 1'b1;
    base = en_seen;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; sndon = 1'b1; mono = 1'b0; rate = 2'b11; sload_n = 1'b1; din = '0;
    repeat (3) step();
    chk("rst_sreq", sreq, 0);
    chk("rst_l", sample_l, 0);
    chk("rst_r", sample_r, 0);
    chk("rst_stb", sample_stb, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);

    // stereo, fastest rate
    reset = 1'b0;
    base = en_seen;
    step();
    chk("sreq_after_reset", sreq, 1);
    chk("no_stb_before_load", obs_q.size(), 0);
    load(16'h7F80, 1);
    take_sample("stereo", 160);
    wait_underrun("stereo_drain");
    chk("hold_l", sample_l, 8'h7F);
    chk("hold_r", sample_r, 8'h80);
    chk("no_stb_on_underrun", obs_q.size(), 0);

    // mono, slowest rate
    restart(1'b1, 2'b00);
    load(16'h1234, 1);
    exp_q.push_back(16'h3434);
    exp_q[0] = 16'h1212;
    take_sample("mono_hi", 1280);
    take_sample("mono_lo", 2560);
    wait_underrun("mono_popped");
    chk("mono_hold_l", sample_l, 8'h34);

    // fill, overrun, then push coincident with a tick
    restart(1'b0, 2'b11);
    load(16'hA1B2, 1);
    load(16'hC3D4, 1);
    load(16'hE5F6, 1);
    load(16'h0718, 1);
    chk("full_sreq", sreq, 0);
    chk("full_count", dut.count_q, 4);
    load(16'h9999, 0);
    chk("overrun_pulse", ovr_cnt, 1);
    chk("overrun_count", dut.count_q, 4);
    chk("overrun_sreq", sreq, 0);
    begin
      int n;
      n = 0;
      while (!(mhz8_en && ((en_seen - base) % 160 == 159)) && n < 2000) begin
        step();
        n++;
      end
      chk("align_tick", n < 2000, 1);
    end
    sload_n = 1'b0;
    din = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    step();
    chk("coinc_count", dut.count_q, 4);
    chk("coinc_no_overrun", overrun, 0);
    sload_n = 1'b1;
    step();
    chk("coinc_ovr_cnt", ovr_cnt, 1);
    take_sample("drain0", 160);
    take_sample("drain1", 320);
    take_sample("drain2", 480);
    take_sample("drain3", 640);
    take_sample("drain4", 800);
    wait_underrun("full_drain");

    // held-low strobe, then stop mid-stream
    restart(1'b0, 2'b11);
    sload_n = 1'b0;
    din = 16'h1111;
    exp_q.push_back(16'h1111);
    repeat (3) step();
    sload_n = 1'b1;
    step();
    chk("held_strobe_once", dut.count_q, 1);
    load(16'h2222, 1);
    take_sample("pre_stop", 160);
    sndon = 1'b0;
    step();
    chk("stop_count", dut.count_q, 0);
    chk("stop_l", sample_l, 0);
    chk("stop_r", sample_r, 0);
    chk("stop_sreq", sreq, 0);
    sload_n = 1'b0;
    din = 16'h3333;
    step();
    chk("stop_push_ignored", dut.count_q, 0);
    sload_n = 1'b1;
    repeat (700) step();
    chk("stop_no_stb", obs_q.size(), 0);

    // reset mid-stream
    restart(1'b0, 2'b11);
    load(16'h3344, 1);
    load(16'h5566, 1);
    take_sample("pre_reset", 160);
    reset = 1'b1;
    step();
    chk("mrst_l", sample_l, 0);
    chk("mrst_r", sample_r, 0);
    chk("mrst_sreq", sreq, 0);
    chk("mrst_stb", sample_stb, 0);
    chk("mrst_count", dut.count_q, 0);
    reset = 1'b0;
    base = en_seen;
    exp_q.delete();
    step();
    chk("mrst_sreq_back", sreq, 1);
    load(16'h7788, 1);
    take_sample("post_reset", 160);
    chk("post_reset_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
